// File: rtl/jtopl_eg_seq.sv
// Time-multiplexed ADSR envelope generator. One operator slot is serviced per
// cen cycle in round-robin order; per-slot state, attenuation and the last seen
// keyon are held internally. Step timing comes from a global envelope counter
// that advances once per full round of slots.
module jtopl_eg_seq #(
    parameter int unsigned  SLOTS = 18,
    parameter int unsigned  EGW   = 10,
    parameter int unsigned  CNTW  = 15,
    localparam int unsigned SW    = $clog2(SLOTS)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cen,
    input  logic           keyon,
    input  logic [3:0]     ar,
    input  logic [3:0]     dr,
    input  logic [3:0]     rr,
    input  logic [3:0]     sl,
    input  logic [3:0]     ks,
    input  logic           eg_type,
    output logic [SW-1:0]  slot_out,
    output logic [EGW-1:0] eg_out,
    output logic [1:0]     state_out,
    output logic           zero
);

    localparam int unsigned EW1 = EGW + 1;
    localparam int unsigned SC  = EGW - 10;

    typedef enum logic [1:0] {
        StAtt = 2'd0,
        StDec = 2'd1,
        StSus = 2'd2,
        StRel = 2'd3
    } eg_state_e;

    logic [SW-1:0]   slot_q, slot_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    eg_state_e       state_q [SLOTS];
    logic [EGW-1:0]  eg_q [SLOTS];
    logic [SLOTS-1:0] kon_q;
    logic [EGW-1:0]  eg_out_q;
    eg_state_e       st_out_q;

    eg_state_e      cur_st, eff_st, next_st;
    logic [EGW-1:0] cur_eg, eg_new;
    logic           cur_kon, kon_on, kon_off;

    logic [3:0]      r_sel;
    logic [6:0]      rate_sum;
    logic [5:0]      rate;
    logic [3:0]      rate_h;
    logic [1:0]      rate_f;
    logic [3:0]      shift;
    logic [CNTW-1:0] cnt_mask;
    logic [2:0]      idx;
    logic [7:0]      pat;
    logic            upd, step;

    logic [3:0]     inc4;
    logic [2:0]     k;
    logic [EGW:0]   inc, sum, dec;
    logic           sl_hit;

    assign cur_st  = state_q[slot_q];
    assign cur_eg  = eg_q[slot_q];
    assign cur_kon = kon_q[slot_q];
    assign kon_on  = keyon & ~cur_kon;
    assign kon_off = ~keyon & cur_kon;
    // A keyon edge switches the state before this cycle's update is applied
    assign eff_st  = kon_on ? StAtt : (kon_off ? StRel : cur_st);

    // Slot pointer and the envelope counter that advances on round wrap
    always_comb begin
        slot_d = slot_q + 1'b1;
        cnt_d  = cnt_q;
        if (slot_q == SW'(SLOTS - 1)) begin
            slot_d = '0;
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // Effective rate of the state being applied, key-scaled and capped at 63
    always_comb begin
        r_sel = rr;
        case (eff_st)
            StAtt:   r_sel = ar;
            StDec:   r_sel = dr;
            StSus:   r_sel = eg_type ? 4'd0 : rr;
            default: r_sel = rr;
        endcase
        rate_sum = {1'b0, r_sel, 2'b00} + {3'b000, ks};
        if (r_sel == 4'd0) begin
            rate = 6'd0;
        end else if (rate_sum > 7'd63) begin
            rate = 6'd63;
        end else begin
            rate = rate_sum[5:0];
        end
    end

    assign rate_h = rate[5:2];
    assign rate_f = rate[1:0];

    // Update gate from the envelope counter and the step pattern bit
    always_comb begin
        shift    = 4'd11 - rate_h;
        cnt_mask = (CNTW'(1) << shift) - CNTW'(1);
        upd      = 1'b0;
        idx      = cnt_q[2:0];
        if (rate == 6'd0) begin
            upd = 1'b0;
        end else if (rate_h >= 4'd12) begin
            upd = 1'b1;
        end else begin
            upd = ((cnt_q & cnt_mask) == '0);
            idx = 3'(cnt_q >> shift);
        end
        case (rate_f)
            2'd0:    pat = 8'b1010_1010;
            2'd1:    pat = 8'b1110_1010;
            2'd2:    pat = 8'b1110_1110;
            default: pat = 8'b1111_1110;
        endcase
        step = pat[idx];
    end

    // Attenuation update: attack shrinks towards 0, other states grow to all ones
    always_comb begin
        case (rate_h)
            4'd12:   inc4 = 4'd2;
            4'd13:   inc4 = 4'd4;
            4'd14:   inc4 = 4'd8;
            4'd15:   inc4 = 4'd15;
            default: inc4 = step ? 4'd2 : 4'd0;
        endcase
        inc = EW1'(inc4) << SC;
        sum = {1'b0, cur_eg} + inc;

        // Rates 60..62 in attack reuse the fastest non-instant divider
        if (rate_h <= 4'd11) begin
            k = 3'd4;
        end else begin
            case (rate_h)
                4'd12:   k = 3'd3;
                4'd13:   k = 3'd2;
                default: k = 3'd1;
            endcase
        end
        dec = ({1'b0, cur_eg} >> k) + EW1'(1);
        if (rate_h >= 4'd12 && step) begin
            dec = dec << 1;
        end

        eg_new = cur_eg;
        if (upd) begin
            if (eff_st == StAtt) begin
                if (rate == 6'd63) begin
                    eg_new = '0;
                end else if (rate_h >= 4'd12 || step) begin
                    eg_new = (dec > {1'b0, cur_eg}) ? '0 : cur_eg - dec[EGW-1:0];
                end
            end else begin
                eg_new = sum[EGW] ? '1 : sum[EGW-1:0];
            end
        end
    end

    // State transitions in priority order: key edges, attack done, sustain level
    always_comb begin
        sl_hit  = (sl == 4'hF) ? (&eg_new) : (eg_new[EGW-1 -: 4] >= sl);
        next_st = eff_st;
        if (!kon_on && !kon_off) begin
            if (cur_st == StAtt && eg_new == '0) begin
                next_st = StDec;
            end else if (cur_st == StDec && sl_hit) begin
                next_st = StSus;
            end
        end
    end

    // Slot pointer, counter, per-slot storage and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q   <= '0;
            cnt_q    <= '0;
            kon_q    <= '0;
            eg_out_q <= '1;
            st_out_q <= StRel;
            for (int i = 0; i < int'(SLOTS); i++) begin
                state_q[i] <= StRel;
                eg_q[i]    <= '1;
            end
        end else if (cen) begin
            slot_q          <= slot_d;
            cnt_q           <= cnt_d;
            state_q[slot_q] <= next_st;
            eg_q[slot_q]    <= eg_new;
            kon_q[slot_q]   <= keyon;
            eg_out_q        <= eg_new;
            st_out_q        <= next_st;
        end
    end

    assign slot_out  = slot_q;
    assign eg_out    = eg_out_q;
    assign state_out = st_out_q;
    assign zero      = (slot_q == '0);

endmodule

// File: tb/tb_jtopl_eg_seq.sv
// Self-checking bench for jtopl_eg_seq: directed ADSR scenarios on a few slots
// followed by randomized per-slot parameters, all checked cycle by cycle
// against an arithmetic reference model of the envelope rules.
module tb_jtopl_eg_seq;

    localparam int SLOTS = 18;
    localparam int EGW   = 10;
    localparam int CNTW  = 15;
    localparam int EGMAX = (1 << EGW) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cen = 1'b0;
    logic           keyon = 1'b0;
    logic           eg_type = 1'b0;
    logic [3:0]     ar = '0, dr = '0, rr = '0, sl = '0, ks = '0;
    logic [4:0]     slot_out;
    logic [EGW-1:0] eg_out;
    logic [1:0]     state_out;
    logic           zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jtopl_eg_seq #(
        .SLOTS (SLOTS),
        .EGW   (EGW),
        .CNTW  (CNTW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .keyon     (keyon),
        .ar        (ar),
        .dr        (dr),
        .rr        (rr),
        .sl        (sl),
        .ks        (ks),
        .eg_type   (eg_type),
        .slot_out  (slot_out),
        .eg_out    (eg_out),
        .state_out (state_out),
        .zero      (zero)
    );

    // per-slot stimulus tables
    logic [3:0] p_ar [SLOTS];
    logic [3:0] p_dr [SLOTS];
    logic [3:0] p_rr [SLOTS];
    logic [3:0] p_sl [SLOTS];
    logic [3:0] p_ks [SLOTS];
    logic       p_type [SLOTS];
    logic       p_kon [SLOTS];

    // reference model state (0 ATT, 1 DEC, 2 SUS, 3 REL)
    int m_state [SLOTS];
    int m_eg [SLOTS];
    bit m_kon [SLOTS];
    int m_slot, m_cnt, m_eg_out, m_st_out;
    int pats [4] = '{8'hAA, 8'hEA, 8'hEE, 8'hFE};

    int ph0 = 0, ph1 = 0, ph2 = 0, ph3 = 0, ph4 = 0;
    int prev4 = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) begin
            m_state[i] = 3;
            m_eg[i]    = EGMAX;
            m_kon[i]   = 1'b0;
        end
        m_slot   = 0;
        m_cnt    = 0;
        m_eg_out = EGMAX;
        m_st_out = 3;
    endtask

    task automatic model_visit(input int n);
        int st, r, rate, h, f, s, idx, eg, k, d, inc;
        bit on, off, upd, step, hit;
        on  = (p_kon[n] === 1'b1) && !m_kon[n];
        off = (p_kon[n] === 1'b0) && m_kon[n];
        st  = on ? 0 : (off ? 3 : m_state[n]);
        case (st)
            0:       r = int'(p_ar[n]);
            1:       r = int'(p_dr[n]);
            2:       r = p_type[n] ? 0 : int'(p_rr[n]);
            default: r = int'(p_rr[n]);
        endcase
        rate = (r == 0) ? 0 : (4 * r + int'(p_ks[n]));
        if (rate > 63) rate = 63;
        h = rate / 4;
        f = rate % 4;
        if (h >= 12) begin
            upd = 1'b1;
            idx = m_cnt % 8;
        end else begin
            s   = 11 - h;
            upd = (rate != 0) && ((m_cnt % (1 << s)) == 0);
            idx = (m_cnt / (1 << s)) % 8;
        end
        step = pats[f][idx];
        eg   = m_eg[n];
        if (upd) begin
            if (st == 0) begin
                if (rate == 63) begin
                    eg = 0;
                end else if (h >= 12 || step) begin
                    k = (h <= 11) ? 4 : ((h == 15) ? 1 : 15 - h);
                    d = (eg >> k) + 1;
                    if (h >= 12 && step) d = 2 * d;
                    eg = (d >= eg) ? 0 : eg - d;
                end
            end else begin
                if (h < 12)       inc = step ? 2 : 0;
                else if (h == 12) inc = 2;
                else if (h == 13) inc = 4;
                else if (h == 14) inc = 8;
                else              inc = 15;
                eg = eg + (inc << (EGW - 10));
                if (eg > EGMAX) eg = EGMAX;
            end
        end
        hit = (p_sl[n] == 4'hF) ? (eg == EGMAX) : ((eg >> (EGW - 4)) >= int'(p_sl[n]));
        if (!on && !off) begin
            if (st == 0 && eg == 0) st = 1;
            else if (st == 1 && hit) st = 2;
        end
        m_state[n] = st;
        m_eg[n]    = eg;
        m_kon[n]   = (p_kon[n] === 1'b1);
        m_eg_out   = eg;
        m_st_out   = st;
        m_slot     = m_slot + 1;
        if (m_slot == SLOTS) begin
            m_slot = 0;
            m_cnt  = (m_cnt + 1) % (1 << CNTW);
        end
    endtask

    // directed scenario checkpoints, run after each serviced slot
    task automatic scenario_hooks(input int n);
        if (n == 0) begin
            if (ph0 == 0) begin
                check_val("fast_att_eg", 32'(eg_out), 32'(0));
                check_val("fast_att_state", 32'(state_out), 32'(0));
                ph0 = 1;
            end else if (ph0 == 1) begin
                check_val("fast_att_dec", 32'(state_out), 32'(1));
                ph0 = 2;
            end
        end
        if (n == 1 && ph1 == 0 && m_cnt >= 40) begin
            check_val("decay_sus_eg", 32'(eg_out), 32'h10E);
            check_val("decay_sus_state", 32'(state_out), 32'(2));
            ph1 = 1;
        end
        if (n == 2) begin
            if (ph2 == 0 && m_state[2] == 1 && m_eg[2] == 'h3F0) begin
                p_kon[2] = 1'b0;
                ph2 = 1;
            end else if (ph2 == 1) begin
                check_val("rel_clamp", 32'(eg_out), 32'h3FF);
                check_val("rel_state", 32'(state_out), 32'(3));
                ph2 = 2;
            end else if (ph2 == 2) begin
                check_val("rel_hold", 32'(eg_out), 32'h3FF);
                check_val("rel_hold_state", 32'(state_out), 32'(3));
                ph2 = 3;
            end
        end
        if (n == 3) begin
            if (ph3 == 0 && m_cnt >= 2000) begin
                check_val("gate_2k", 32'(eg_out), 32'(2));
                ph3 = 1;
            end else if (ph3 == 1 && m_cnt >= 3073) begin
                check_val("gate_3k", 32'(eg_out), 32'(4));
                check_val("gate_state", 32'(state_out), 32'(1));
                ph3 = 2;
            end
        end
        if (n == 4) begin
            if (ph4 == 0 && m_state[4] == 2) begin
                check_val("sus_level", 32'(eg_out), 32'h200);
                p_kon[4] = 1'b0;
                ph4 = 1;
            end else if (ph4 == 1) begin
                check_val("retrig_rel", 32'(eg_out), 32'h200);
                check_val("retrig_rel_state", 32'(state_out), 32'(3));
                p_kon[4] = 1'b1;
                p_ar[4]  = 4'd10;
                prev4    = 'h200;
                ph4 = 2;
            end else if (ph4 == 2) begin
                check_val("retrig_att", 32'(state_out), 32'(0));
                check_val("retrig_mono", 32'(int'(eg_out) <= prev4), 32'(1));
                prev4 = int'(eg_out);
                ph4 = 3;
            end else if (ph4 == 3) begin
                check_val("retrig_mono", 32'(int'(eg_out) <= prev4), 32'(1));
                prev4 = int'(eg_out);
                if (m_state[4] == 1) begin
                    check_val("retrig_done", 32'(eg_out), 32'(0));
                    ph4 = 4;
                end
            end
        end
    endtask

    task automatic run_cycle(input bit en, input bit hooks);
        int n;
        n       = m_slot;
        cen     = en;
        keyon   = p_kon[n];
        ar      = p_ar[n];
        dr      = p_dr[n];
        rr      = p_rr[n];
        sl      = p_sl[n];
        ks      = p_ks[n];
        eg_type = p_type[n];
        @(posedge clk);
        if (en) model_visit(n);
        #1;
        check_val("slot_out", 32'(slot_out), 32'(m_slot));
        check_val("zero", 32'(zero), 32'(m_slot == 0));
        check_val("eg_out", 32'(eg_out), 32'(m_eg_out));
        check_val("state_out", 32'(state_out), 32'(m_st_out));
        if (en && hooks) scenario_hooks(n);
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_eg"}, 32'(eg_out), 32'h3FF);
        check_val({tag, "_state"}, 32'(state_out), 32'(3));
        check_val({tag, "_slot"}, 32'(slot_out), 32'(0));
        check_val({tag, "_zero"}, 32'(zero), 32'(1));
    endtask

    task automatic randomize_slot(input int i);
        p_ar[i]   = 4'($urandom_range(0, 15));
        p_dr[i]   = 4'($urandom_range(0, 15));
        p_rr[i]   = 4'($urandom_range(0, 15));
        p_sl[i]   = 4'($urandom_range(0, 15));
        p_ks[i]   = 4'($urandom_range(0, 15));
        p_type[i] = 1'($urandom_range(0, 1));
    endtask

    function automatic bit main_done();
        return ph0 == 2 && ph1 == 1 && ph2 == 3 && ph3 == 2 && ph4 == 4;
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        model_reset();
        for (int i = 0; i < SLOTS; i++) begin
            randomize_slot(i);
            p_kon[i] = 1'b0;
        end
        // slot 0: instant attack, then holds at 0 in decay
        p_ar[0] = 4'd15; p_ks[0] = 4'd15; p_dr[0] = 4'd0; p_sl[0] = 4'd15;
        p_type[0] = 1'b1; p_kon[0] = 1'b1;
        // slot 1: fast decay to sustain level 4, held
        p_ar[1] = 4'd15; p_dr[1] = 4'd15; p_rr[1] = 4'd0; p_ks[1] = 4'd3;
        p_sl[1] = 4'd4; p_type[1] = 1'b1; p_kon[1] = 1'b1;
        // slot 2: decay by 2 per visit up to 0x3F0, then fast release clamp
        p_ar[2] = 4'd15; p_dr[2] = 4'd12; p_rr[2] = 4'd15; p_ks[2] = 4'd3;
        p_sl[2] = 4'd15; p_type[2] = 1'b1; p_kon[2] = 1'b1;
        // slot 3: slow decay rate 4, gated on eg_cnt[9:0]==0
        p_ar[3] = 4'd15; p_dr[3] = 4'd1; p_rr[3] = 4'd0; p_ks[3] = 4'd0;
        p_sl[3] = 4'd15; p_type[3] = 1'b1; p_kon[3] = 1'b1;
        // slot 4: sustain at 0x200, release holding there, then retrigger
        p_ar[4] = 4'd15; p_dr[4] = 4'd12; p_rr[4] = 4'd0; p_ks[4] = 4'd3;
        p_sl[4] = 4'd8; p_type[4] = 1'b1; p_kon[4] = 1'b1;

        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        cyc = 0;
        while (!main_done() && cyc < 80000) begin
            run_cycle($urandom_range(0, 9) != 0, 1'b1);
            cyc++;
        end
        check_val("main_scenarios_done", 32'(main_done()), 32'(1));

        // asynchronous reset in the middle of a cycle
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        model_reset();
        cen = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("reset_held");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < SLOTS; i++) begin
            randomize_slot(i);
            p_kon[i] = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c < 9000; c++) begin
            if ($urandom_range(0, 15) == 0) randomize_slot(int'($urandom_range(0, SLOTS - 1)));
            if ($urandom_range(0, 5) == 0) begin
                int j;
                j = int'($urandom_range(0, SLOTS - 1));
                p_kon[j] = ~p_kon[j];
            end
            run_cycle($urandom_range(0, 4) != 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
